// File: rtl/hwpe_dma_loader.sv
// DMA loader that copies FMAP1, FMAP2 and KERNEL words from a source memory
// into the HWPE SRAMs through the hwpe DMA write port, then pulses done.
module hwpe_dma_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int SRC_AW     = 32,
  parameter int CNT_W      = 16,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SRC_AW-1:0]     fmap_src_base,
  input  logic [SRC_AW-1:0]     fmap2_src_off,
  input  logic [CNT_W-1:0]      fmap_words,
  input  logic [ADDR_WIDTH-1:0] fmap2_dst_base,
  input  logic [SRC_AW-1:0]     kernel_src_base,
  input  logic [CNT_W-1:0]      kernel_words,
  input  logic [ADDR_WIDTH-1:0] kernel_dst_base,
  output logic                  src_req_valid,
  input  logic                  src_req_ready,
  output logic [SRC_AW-1:0]     src_req_addr,
  input  logic                  src_rsp_valid,
  input  logic [63:0]           src_rsp_data,
  output logic                  dma_wen,
  output logic [ADDR_WIDTH-1:0] dma_wa,
  output logic [63:0]           dma_wd,
  output logic                  busy,
  output logic                  done,
  output logic                  proto_err
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_FMAP1 = 3'd1,
    R_FMAP2 = 3'd2,
    R_KERN  = 3'd3,
    R_WAIT  = 3'd4
  } phase_e;

  // Phase ordering shared by the request and response sides; empty phases are skipped.
  function automatic phase_e next_phase(input phase_e p, input logic f_nz, input logic k_nz);
    phase_e n;
    case (p)
      R_IDLE:  n = f_nz ? R_FMAP1 : (k_nz ? R_KERN : R_WAIT);
      R_FMAP1: n = R_FMAP2;
      R_FMAP2: n = k_nz ? R_KERN : R_WAIT;
      default: n = R_WAIT;
    endcase
    return n;
  endfunction

  phase_e                rstate_q, rstate_d;
  phase_e                pstate_q, pstate_d;
  logic [CNT_W-1:0]      ridx_q, ridx_d;
  logic [CNT_W-1:0]      widx_q, widx_d;
  logic [OUT_W-1:0]      outst_q, outst_d;

  logic [SRC_AW-1:0]     fsrc_q, fsrc_d;
  logic [SRC_AW-1:0]     f2src_q, f2src_d;
  logic [SRC_AW-1:0]     ksrc_q, ksrc_d;
  logic [CNT_W-1:0]      fcnt_q, fcnt_d;
  logic [CNT_W-1:0]      kcnt_q, kcnt_d;
  logic [ADDR_WIDTH-1:0] f2dst_q, f2dst_d;
  logic [ADDR_WIDTH-1:0] kdst_q, kdst_d;

  logic                  req_valid_q, req_valid_d;
  logic [SRC_AW-1:0]     req_addr_q, req_addr_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [63:0]           wd_q, wd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;

  logic                  req_hs;
  logic                  rsp_ok;
  logic                  req_data_phase;
  logic [CNT_W-1:0]      rcnt;
  logic [CNT_W-1:0]      pcnt;
  logic [SRC_AW-1:0]     req_base;
  logic [ADDR_WIDTH-1:0] dst_base;

  always_comb begin
    rstate_d = rstate_q;
    pstate_d = pstate_q;
    ridx_d   = ridx_q;
    widx_d   = widx_q;
    fsrc_d   = fsrc_q;
    f2src_d  = f2src_q;
    ksrc_d   = ksrc_q;
    fcnt_d   = fcnt_q;
    kcnt_d   = kcnt_q;
    f2dst_d  = f2dst_q;
    kdst_d   = kdst_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wen_d    = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;

    req_hs  = req_valid_q & src_req_ready;
    rsp_ok  = src_rsp_valid & (outst_q != '0);
    outst_d = outst_q + OUT_W'(req_hs) - OUT_W'(rsp_ok);
    perr_d  = perr_q | (src_rsp_valid & (outst_q == '0));

    rcnt = (rstate_q == R_KERN) ? kcnt_q : fcnt_q;
    pcnt = (pstate_q == R_KERN) ? kcnt_q : fcnt_q;

    case (rstate_q)
      R_IDLE: begin
        if (start) begin
          fsrc_d   = fmap_src_base;
          f2src_d  = fmap_src_base + fmap2_src_off;
          ksrc_d   = kernel_src_base;
          fcnt_d   = fmap_words;
          kcnt_d   = kernel_words;
          f2dst_d  = fmap2_dst_base;
          kdst_d   = kernel_dst_base;
          rstate_d = next_phase(R_IDLE, fmap_words != '0, kernel_words != '0);
          pstate_d = next_phase(R_IDLE, fmap_words != '0, kernel_words != '0);
          ridx_d   = '0;
          widx_d   = '0;
          busy_d   = 1'b1;
        end
      end
      R_FMAP1, R_FMAP2, R_KERN: begin
        if (req_hs) begin
          if (ridx_q + CNT_W'(1) == rcnt) begin
            rstate_d = next_phase(rstate_q, fcnt_q != '0, kcnt_q != '0);
            ridx_d   = '0;
          end else begin
            ridx_d = ridx_q + CNT_W'(1);
          end
        end
      end
      R_WAIT: begin
        if (pstate_q == R_WAIT && outst_q == '0) begin
          rstate_d = R_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    // Response side tracks its own phase so writes land correctly regardless of request progress.
    case (pstate_q)
      R_FMAP2: dst_base = f2dst_q;
      R_KERN:  dst_base = kdst_q;
      default: dst_base = '0;
    endcase
    if (rsp_ok) begin
      wen_d = 1'b1;
      wa_d  = dst_base + (ADDR_WIDTH'(widx_q) << 3);
      wd_d  = src_rsp_data;
      if (widx_q + CNT_W'(1) == pcnt) begin
        pstate_d = next_phase(pstate_q, fcnt_q != '0, kcnt_q != '0);
        widx_d   = '0;
      end else begin
        widx_d = widx_q + CNT_W'(1);
      end
    end

    // Request outputs are computed from next-state so they stay registered.
    case (rstate_d)
      R_FMAP2: req_base = f2src_d;
      R_KERN:  req_base = ksrc_d;
      default: req_base = fsrc_d;
    endcase
    req_data_phase = (rstate_d == R_FMAP1) || (rstate_d == R_FMAP2) || (rstate_d == R_KERN);
    req_valid_d    = req_data_phase && (outst_d < OUT_W'(MAX_OUTST));
    req_addr_d     = req_data_phase ?
                     ((req_base + (SRC_AW'(ridx_d) << 3)) & ~SRC_AW'(7)) : req_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q    <= R_IDLE;
      pstate_q    <= R_IDLE;
      ridx_q      <= '0;
      widx_q      <= '0;
      outst_q     <= '0;
      fsrc_q      <= '0;
      f2src_q     <= '0;
      ksrc_q      <= '0;
      fcnt_q      <= '0;
      kcnt_q      <= '0;
      f2dst_q     <= '0;
      kdst_q      <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      wen_q       <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      rstate_q    <= rstate_d;
      pstate_q    <= pstate_d;
      ridx_q      <= ridx_d;
      widx_q      <= widx_d;
      outst_q     <= outst_d;
      fsrc_q      <= fsrc_d;
      f2src_q     <= f2src_d;
      ksrc_q      <= ksrc_d;
      fcnt_q      <= fcnt_d;
      kcnt_q      <= kcnt_d;
      f2dst_q     <= f2dst_d;
      kdst_q      <= kdst_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      wen_q       <= wen_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      perr_q      <= perr_d;
    end
  end

  assign src_req_valid = req_valid_q;
  assign src_req_addr  = req_addr_q;
  assign dma_wen       = wen_q;
  assign dma_wa        = wa_q;
  assign dma_wd        = wd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign proto_err     = perr_q;

endmodule

// File: tb/tb_hwpe_dma_loader.sv
// Bench for hwpe_dma_loader: a modelled source memory with configurable latency
// and readiness, and an expected write list derived from the region layout.
module tb_hwpe_dma_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] fmap_src_base = '0;
  logic [31:0] fmap2_src_off = '0;
  logic [15:0] fmap_words = '0;
  logic [15:0] fmap2_dst_base = '0;
  logic [31:0] kernel_src_base = '0;
  logic [15:0] kernel_words = '0;
  logic [15:0] kernel_dst_base = '0;
  logic        src_req_valid;
  logic        src_req_ready = 1'b0;
  logic [31:0] src_req_addr;
  logic        src_rsp_valid = 1'b0;
  logic [63:0] src_rsp_data = '0;
  logic        dma_wen;
  logic [15:0] dma_wa;
  logic [63:0] dma_wd;
  logic        busy;
  logic        done;
  logic        proto_err;

  always #5 clk = ~clk;

  hwpe_dma_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .fmap_src_base  (fmap_src_base),
    .fmap2_src_off  (fmap2_src_off),
    .fmap_words     (fmap_words),
    .fmap2_dst_base (fmap2_dst_base),
    .kernel_src_base(kernel_src_base),
    .kernel_words   (kernel_words),
    .kernel_dst_base(kernel_dst_base),
    .src_req_valid  (src_req_valid),
    .src_req_ready  (src_req_ready),
    .src_req_addr   (src_req_addr),
    .src_rsp_valid  (src_rsp_valid),
    .src_rsp_data   (src_rsp_data),
    .dma_wen        (dma_wen),
    .dma_wa         (dma_wa),
    .dma_wd         (dma_wd),
    .busy           (busy),
    .done           (done),
    .proto_err      (proto_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit quiet = 1'b1;
  bit rnd_mode = 1'b0;
  logic [31:0] rq_addr[$];
  int          rq_due[$];
  int outst_m = 0;
  int outst_max = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  logic [15:0] obs_a[$];
  logic [63:0] obs_d[$];
  logic [15:0] exp_a[$];
  logic [63:0] exp_d[$];

  // Source image: every 8-byte-aligned address holds a distinct word.
  function automatic logic [63:0] mem(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a * 32'h9E37_79B9};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: observe DUT outputs at negedge, then drive the memory responder.
  task automatic tick();
    bit hs;
    bit rsp;
    @(negedge clk);
    cyc++;
    if (dma_wen) begin
      obs_a.push_back(dma_wa);
      obs_d.push_back(dma_wd);
    end
    if (done) done_cnt++;
    if (src_req_valid) req_cnt++;
    if (quiet) begin
      src_req_ready = 1'b0;
      src_rsp_valid = 1'b0;
    end else begin
      src_req_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
      hs = src_req_valid && src_req_ready;
      rsp = 1'b0;
      if (hs) begin
        rq_addr.push_back(src_req_addr);
        rq_due.push_back(cyc + (rnd_mode ? int'($urandom_range(1, 6)) : 1));
      end
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        rsp = 1'b1;
        src_rsp_valid = 1'b1;
        src_rsp_data = mem(rq_addr.pop_front());
        void'(rq_due.pop_front());
      end else begin
        src_rsp_valid = 1'b0;
      end
      outst_m += int'(hs) - int'(rsp);
      if (outst_m > outst_max) outst_max = outst_m;
    end
  endtask

  task automatic set_cfg(input logic [31:0] fsrc, input logic [31:0] off, input logic [15:0] fw,
                         input logic [15:0] f2d, input logic [31:0] ksrc, input logic [15:0] kw,
                         input logic [15:0] kd);
    fmap_src_base   = fsrc;
    fmap2_src_off   = off;
    fmap_words      = fw;
    fmap2_dst_base  = f2d;
    kernel_src_base = ksrc;
    kernel_words    = kw;
    kernel_dst_base = kd;
    exp_a.delete();
    exp_d.delete();
    for (int j = 0; j < int'(fw); j++) begin
      exp_a.push_back(16'(j * 8));
      exp_d.push_back(mem((fsrc & ~32'h7) + 32'(j * 8)));
    end
    for (int j = 0; j < int'(fw); j++) begin
      exp_a.push_back(f2d + 16'(j * 8));
      exp_d.push_back(mem(((fsrc + off) & ~32'h7) + 32'(j * 8)));
    end
    for (int j = 0; j < int'(kw); j++) begin
      exp_a.push_back(kd + 16'(j * 8));
      exp_d.push_back(mem((ksrc & ~32'h7) + 32'(j * 8)));
    end
  endtask

  task automatic clear_rec();
    obs_a.delete();
    obs_d.delete();
    done_cnt = 0;
    req_cnt = 0;
    outst_max = 0;
  endtask

  task automatic check_writes(input string tag);
    int n;
    int bad;
    chk({tag, " write count"}, 64'(obs_a.size()), 64'(exp_a.size()));
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    bad = n - 1;
    for (int i = n - 1; i >= 0; i--) begin
      if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) bad = i;
    end
    if (n > 0) begin
      chk($sformatf("%s wa[%0d]", tag, bad), 64'(obs_a[bad]), 64'(exp_a[bad]));
      chk($sformatf("%s wd[%0d]", tag, bad), obs_d[bad], exp_d[bad]);
    end
  endtask

  task automatic run(input string tag, input int restart_at);
    bit restarted;
    restarted = 1'b0;
    clear_rec();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy after start"}, 64'(busy), 64'd1);
    // Configuration must be latched; scramble the live inputs.
    fmap_src_base   = $urandom;
    fmap2_src_off   = $urandom;
    fmap_words      = 16'($urandom);
    fmap2_dst_base  = 16'($urandom);
    kernel_src_base = $urandom;
    kernel_words    = 16'($urandom);
    kernel_dst_base = 16'($urandom);
    for (int k = 0; k < 20000 && done_cnt == 0; k++) begin
      if (!restarted && restart_at >= 0 && obs_a.size() >= restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk({tag, " done seen"}, 64'(done_cnt > 0), 64'd1);
    for (int k = 0; k < 6; k++) tick();
    chk({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, " busy after done"}, 64'(busy), 64'd0);
    check_writes(tag);
    $display("[TB] %s: %0d writes, %0d done pulses, max outstanding %0d",
             tag, obs_a.size(), done_cnt, outst_max);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " src_req_valid"}, 64'(src_req_valid), 64'd0);
    chk({tag, " src_req_addr"}, 64'(src_req_addr), 64'd0);
    chk({tag, " dma_wen"}, 64'(dma_wen), 64'd0);
    chk({tag, " dma_wa"}, 64'(dma_wa), 64'd0);
    chk({tag, " dma_wd"}, dma_wd, 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " proto_err"}, 64'(proto_err), 64'd0);
  endtask

  initial begin
    logic [15:0] rw;
    // Reset state
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b0;
    tick();
    chk_all_zero("reset");

    // Full test-plan transfer, always-ready source, 1-cycle latency
    quiet = 1'b0;
    rnd_mode = 1'b0;
    set_cfg(32'h1000_0000, 32'h910, 16'd289, 16'h8000, 32'h2000_0008, 16'd576, 16'hC000);
    chk("A first wa", 64'(exp_a[0]), 64'h0000);
    run("A full", -1);

    // Same transfer with random readiness and latency
    rnd_mode = 1'b1;
    set_cfg(32'h1000_0000, 32'h910, 16'd289, 16'h8000, 32'h2000_0008, 16'd576, 16'hC000);
    run("B random timing", -1);
    chk("B max outstanding <= 4", 64'(outst_max <= 4), 64'd1);
    chk("B outstanding drained", 64'(outst_m), 64'd0);

    // FMAP regions empty
    rnd_mode = 1'b0;
    set_cfg(32'h3000_0000, 32'h100, 16'd0, 16'h8000, 32'h4000_0000, 16'd3, 16'hC000);
    run("C kernel only", -1);

    // Random config with unaligned source bases and wrapping addresses
    rnd_mode = 1'b1;
    rw = 16'($urandom_range(1, 20));
    set_cfg(32'hFFFF_FF00 | $urandom_range(0, 255), 32'($urandom_range(0, 64)) << 3, rw,
            16'($urandom_range(0, 4095)) << 3, 32'hFFFF_FFC0 | $urandom_range(0, 63),
            16'($urandom_range(0, 20)), 16'hFFC0);
    run("D random config", -1);

    // All counts zero
    rnd_mode = 1'b0;
    set_cfg(32'h0, 32'h0, 16'd0, 16'h8000, 32'h0, 16'd0, 16'hC000);
    clear_rec();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("E busy cycle 1", 64'(busy), 64'd1);
    chk("E done cycle 1", 64'(done), 64'd0);
    tick();
    chk("E done cycle 2", 64'(done), 64'd1);
    chk("E busy cycle 2", 64'(busy), 64'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("E no requests", 64'(req_cnt), 64'd0);
    chk("E no writes", 64'(obs_a.size()), 64'd0);
    chk("E done pulses", 64'(done_cnt), 64'd1);
    $display("[TB] E all-zero: %0d requests, %0d writes, %0d done pulses",
             req_cnt, obs_a.size(), done_cnt);

    // start re-pulsed while FMAP2 is being written
    set_cfg(32'h1000_0000, 32'h910, 16'd289, 16'h8000, 32'h2000_0008, 16'd576, 16'hC000);
    run("F restart ignored", 400);

    // Reset mid-transfer, then a stray response
    set_cfg(32'h1000_0000, 32'h910, 16'd289, 16'h8000, 32'h2000_0008, 16'd576, 16'hC000);
    clear_rec();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5000 && obs_a.size() < 100; k++) tick();
    chk("G reached write 100", 64'(obs_a.size() >= 100), 64'd1);
    rst = 1'b1;
    quiet = 1'b1;
    src_req_ready = 1'b0;
    src_rsp_valid = 1'b0;
    rq_addr.delete();
    rq_due.delete();
    outst_m = 0;
    tick();
    chk_all_zero("G after reset");
    rst = 1'b0;
    tick();
    clear_rec();
    src_rsp_valid = 1'b1;
    src_rsp_data = 64'hDEAD_BEEF_0123_4567;
    tick();
    tick();
    chk("G proto_err set", 64'(proto_err), 64'd1);
    chk("G stray response not written", 64'(obs_a.size()), 64'd0);
    $display("[TB] G reset+stray response: proto_err=%0d writes=%0d", proto_err, obs_a.size());
    quiet = 1'b0;
    set_cfg(32'h1000_0000, 32'h910, 16'd289, 16'h8000, 32'h2000_0008, 16'd576, 16'hC000);
    run("G post-reset", -1);
    chk("G proto_err sticky", 64'(proto_err), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hwpe_dma_loader.md
Name: hwpe_dma_loader

Overview:
- Synthesizable DMA engine that fills the HWPE feature-map and kernel SRAMs through the existing hwpe DMA write port (dma_wen/dma_wa/dma_wd) before the EAI instruction stream starts.
- Sits directly upstream of hwpe. It reads 64-bit words from a source memory over a simple request/response port.
- Writes three regions in fixed order: FMAP1, FMAP2 (overlap-aware source offset), then KERNEL. Then it signals done.

Parameters:
- ADDR_WIDTH, 16: width of dma_wa; equals HWPE_ADDR_WIDTH.
- SRC_AW, 32: source byte-address width.
- CNT_W, 16: width of word-count inputs.
- MAX_OUTST, 4: maximum outstanding source reads (power of 2, ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle start pulse; sampled in IDLE only
- fmap_src_base  in  SRC_AW  source byte address of FMAP1 data
- fmap2_src_off  in  SRC_AW  byte offset from fmap_src_base to FMAP2 data
- fmap_words  in  CNT_W  64-bit words per FMAP region
- fmap2_dst_base  in  ADDR_WIDTH  hwpe address of FMAP2 SRAM (FMEM_ADDR2_START)
- kernel_src_base  in  SRC_AW  source byte address of kernel data
- kernel_words  in  CNT_W  64-bit kernel words
- kernel_dst_base  in  ADDR_WIDTH  hwpe address of kernel SRAM (KMEM_ADDR_START)
- src_req_valid  out  1  read request valid
- src_req_ready  in  1  read request accepted
- src_req_addr  out  SRC_AW  8-byte-aligned read address
- src_rsp_valid  in  1  read data valid; responses arrive in order; no backpressure
- src_rsp_data  in  64  read data; the byte at the lowest address is in bits [7:0]
- dma_wen  out  1  hwpe SRAM write enable
- dma_wa  out  ADDR_WIDTH  hwpe write byte address
- dma_wd  out  64  hwpe write data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- proto_err  out  1  sticky; set by a response arriving with zero outstanding

Behaviour:
- Configuration inputs are latched on the accepted start. Later changes to them are ignored until the next start.
- Request side FSM: R_IDLE -> R_FMAP1 -> R_FMAP2 -> R_KERN -> R_WAIT -> R_IDLE.
  - start in R_IDLE: latch config, set busy=1, go to R_FMAP1.
  - A phase with zero words is skipped in the same cycle its predecessor would exit. If all counts are 0, go straight to R_WAIT.
  - Request addresses per phase:
    - FMAP1: fmap_src_base + 8*i
    - FMAP2: fmap_src_base + fmap2_src_off + 8*i
    - KERN: kernel_src_base + 8*i
    - i runs 0..words-1.
  - src_req_valid=1 in the three data phases while outstanding < MAX_OUTST. Address and valid are held stable until src_req_ready.
  - On the handshake of the last word of a phase, advance to the next phase.
- Outstanding counter: +1 on request handshake, -1 on src_rsp_valid, net 0 when both occur in the same cycle. Never exceeds MAX_OUTST.
- Response side keeps its own phase and word counter, independent of the request side.
  - Destination addresses per phase:
    - FMAP1: 8*j
    - FMAP2: fmap2_dst_base + 8*j
    - KERN: kernel_dst_base + 8*j
  - Zero-word phases are skipped identically on this side.
- Write timing: src_rsp_valid in cycle t gives dma_wen=1 in cycle t+1.
  - dma_wa is the destination address; dma_wd equals src_rsp_data unmodified.
  - Both are registered. dma_wa/dma_wd hold their last value while dma_wen=0.
- R_WAIT completion: when the response side has consumed all words and outstanding==0, pulse done=1 for one cycle.
  - done occurs the cycle after the final dma_wen cycle, or the cycle after entering R_WAIT if there were zero words.
  - In the done cycle busy drops to 0 and the FSM returns to R_IDLE.
- start while busy: ignored, with no effect on state.
- Address arithmetic:
  - Source addresses wrap modulo 2^SRC_AW; destination addresses wrap modulo 2^ADDR_WIDTH.
  - src_req_addr[2:0] is always 0; low bits of the base inputs are masked off.
- Protocol error: src_rsp_valid with outstanding==0 sets proto_err and produces no write. proto_err clears only on rst.
- Reset, synchronous, also mid-transfer:
  - Next cycle all outputs are 0 (src_req_valid, src_req_addr, dma_wen, dma_wa, dma_wd, busy, done, proto_err).
  - Counters and FSMs go to idle state.
  - Responses to pre-reset requests that arrive after reset count as proto_err.

Test Plan:
- fmap_words=289, fmap2_dst_base=0x8000, fmap2_src_off=0x910, kernel_words=576, kernel_dst_base=0xC000, src always ready with 1-cycle latency:
  - 1154 writes total.
  - Addresses: 0x0000..0x0900, then 0x8000..0x8900, then 0xC000..0xD1F8.
  - Data byte-matches the source image; done is one pulse.
- Random src_req_ready at 30% and response latency 1–6 cycles, MAX_OUTST=4:
  - Outstanding never exceeds 4.
  - Write sequence is identical to the previous scenario.
- fmap_words=0, kernel_words=3 -> exactly 3 writes at kernel_dst_base+0/8/16; done follows.
- All counts 0 -> no src_req_valid and no dma_wen; done 2 cycles after start; busy high for 1 cycle.
- start re-pulsed mid-FMAP2 -> ignored; write count unchanged.
- rst at write #100, then an extra src_rsp_valid -> outputs 0 next cycle; proto_err=1; a subsequent start runs a full correct transfer.
